multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter MEM_HANDSHAKE, default 1. When 1, FETCH and MEM wait for mem_ack. When 0, mem_ack is ignored and treated as 1.
REQ-003 Parameter TRAP_STICKY, default 1. When 1, an illegal opcode halts the block until reset. When 0, it flags and resumes at FETCH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inst  input  32  instruction register contents, valid from DECODE onward.
REQ-007 BrEq, BrLt  input  1 each  branch comparator results.
REQ-008 mem_ack  input  1  memory completed the current request.
REQ-009 mem_req  output  1  memory request; held high until acked.
REQ-010 IRWrite, PCWrite  output  1 each  load the IR; load the PC.
REQ-011 PCSel, RegWEn, BrUn, ASel, BSel, MemRW, IorD  output  1 each  datapath selects. MemRW: 1 = write. IorD: 1 = data address.
REQ-012 WBSel  output  2  0 = mem, 1 = ALU, 2 = PC+4.
REQ-013 ImmSel  output  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
REQ-014 ALUSel  output  4  ALU operation code from the shared package.
REQ-015 illegal, halted  output  1 each  illegal-opcode pulse; sticky halt.

Function
REQ-016 States are FETCH, DECODE, EXEC, MEM, WB and TRAP. Reset state is FETCH.
REQ-017 FETCH: mem_req=1, IorD=0, MemRW=0.
  - On mem_ack: IRWrite=1, PCWrite=1, PCSel=0 (PC+4), then go to DECODE.
  - Without mem_ack: stay in FETCH with all writes 0.
REQ-018 DECODE: decodes inst[6:2].
  - Opcodes R, I-arith, load, store, branch, JAL, JALR, LUI, AUIPC go to EXEC.
  - Any other opcode, or inst[1:0]!=2'b11, goes to TRAP.
REQ-019 EXEC, R/I-arith/LUI/AUIPC: drive ALUSel per funct3/inst[30]; go to WB.
  - inst[30] is used for SUB/SRA, and for SRAI only.
  - ADDI and other I-type ops ignore inst[30].
REQ-020 EXEC, load/store: ALUSel=ADD, BSel=1, ImmSel=I (load) or S (store); go to MEM.
REQ-021 EXEC, branch: BrUn=funct3[1]. PCWrite=1 only when taken, with PCSel=1. Go to FETCH.
  - Taken rules: BEQ on BrEq, BNE on !BrEq, BLT/BLTU on BrLt, BGE/BGEU on !BrLt.
  - funct3 010 or 011 is illegal and goes to TRAP.
REQ-022 EXEC, JAL/JALR: RegWEn=1, WBSel=2, PCWrite=1, PCSel=1, in the same cycle; go to FETCH.
  - JAL: ImmSel=J.
  - JALR: ImmSel=I and ASel=0.
REQ-023 MEM: mem_req=1, IorD=1, MemRW=1 for store.
  - On mem_ack, a store goes to FETCH and a load goes to WB.
  - Without mem_ack, stay in MEM.
REQ-024 WB: RegWEn=1 for exactly one cycle. WBSel=0 for load, 1 otherwise. Go to FETCH.
REQ-025 Cycle counts with zero-wait memory:
  - branch/JAL/JALR: 3
  - ALU/store: 4
  - load: 5
  - each wait cycle adds 1.
REQ-026 Strobe rules:
  - RegWEn, PCWrite and IRWrite are never high outside the cycles listed above.
  - MemRW=1 only in MEM for a store.
REQ-027 TRAP: illegal=1 for the entry cycle only.
  - TRAP_STICKY=1: halted=1 and the block remains in TRAP.
  - TRAP_STICKY=0: return to FETCH next cycle.
REQ-028 XLEN=64 additionally accepts the OP-32 and OP-IMM-32 opcodes. ALUSel uses W-variant codes for these. XLEN=32 treats them as illegal.

Reset
REQ-029 Reset asserted: state=FETCH, halted=0, and all outputs 0 (ALUSel=ADD=0), asynchronously.
REQ-030 Reset mid-MEM or mid-FETCH drops mem_req in the same cycle. No write strobe fires.
REQ-031 The first FETCH request issues on the first rising edge after rst deasserts.

Structure
REQ-032 Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUSel codes: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPYB, plus W-variants
  - ImmSel and WBSel encodings
REQ-033 One sub-module, alu_decode, is combinational. It maps opcode, funct3, inst[30] and XLEN to ALUSel and ImmSel. The FSM lives in multicycle_ctrl.

Verification
REQ-034 add x3,x1,x2 (0x002081B3), ack every cycle -> RegWEn high in cycle 4 only, WBSel=1, ALUSel=ADD.
REQ-035 lw with mem_ack delayed 2 cycles in MEM -> 7 total cycles; RegWEn high in cycle 7 only, WBSel=0.
REQ-036 beq: BrEq=1 -> PCWrite in cycle 3 with PCSel=1. BrEq=0 -> no cycle-3 PCWrite.
REQ-037 Opcode 7'b1111111, TRAP_STICKY=1 -> illegal pulses once, halted=1, mem_req stays 0 for 10 cycles.
REQ-038 rst asserted in MEM during a sw -> mem_req, MemRW and all strobes 0 in the same cycle; restart at FETCH.
REQ-039 XLEN=32 with addw -> TRAP. XLEN=64 with addw -> WB with ALUSel=ADDW.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV controller: FSM states, opcode
// field values (inst[6:2]), ALU operation codes, immediate and write-back selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Major opcode, inst[6:2]
  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;

  // ALU operation codes (ADD must stay 0: it is the idle/reset value)
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;
  localparam logic [3:0] ALU_ADDW  = 4'd11;
  localparam logic [3:0] ALU_SUBW  = 4'd12;
  localparam logic [3:0] ALU_SLLW  = 4'd13;
  localparam logic [3:0] ALU_SRLW  = 4'd14;
  localparam logic [3:0] ALU_SRAW  = 4'd15;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // True when the instruction can be executed; branch funct3 010/011 is reserved
  function automatic logic inst_legal(input logic [6:0] op7, input logic [2:0] f3,
                                      input logic is64);
    logic ok;
    ok = 1'b0;
    if (op7[1:0] == 2'b11) begin
      case (op7[6:2])
        OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
        OPC_OP, OPC_LUI, OPC_JAL, OPC_JALR:       ok = 1'b1;
        OPC_BRANCH:                               ok = (f3[2:1] != 2'b01);
        OPC_OP_32, OPC_OP_IMM_32:                 ok = is64;
        default:                                  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request channel of the controller.
// Handshake: mem_req acts as valid, mem_ack as ready. A request completes on
// the rising edge where both are high; until then mem_req stays high and
// IorD/MemRW stay stable. mem_ack is ignored while mem_req is low.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ack;
  logic MemRW;
  logic IorD;

  modport master (output mem_req, output MemRW, output IorD, input mem_ack);
  modport slave  (input mem_req, input MemRW, input IorD, output mem_ack);
endinterface

// File: rtl/alu_decode.sv
// Combinational decode of ALU operation and immediate format from the
// opcode, funct3 and inst[30].
module alu_decode
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       inst30_i,
  output logic [3:0] alu_sel_o,
  output logic [2:0] imm_sel_o
);

  localparam bit IS64 = (XLEN == 64);

  // inst[30] selects SUB only for register ops; for shifts it picks SRA/SRAI
  always_comb begin
    alu_sel_o = ALU_ADD;
    imm_sel_o = IMM_I;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3_i)
          3'b000:  alu_sel_o = (opcode_i == OPC_OP && inst30_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_sel_o = ALU_SLL;
          3'b010:  alu_sel_o = ALU_SLT;
          3'b011:  alu_sel_o = ALU_SLTU;
          3'b100:  alu_sel_o = ALU_XOR;
          3'b101:  alu_sel_o = inst30_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_sel_o = ALU_OR;
          default: alu_sel_o = ALU_AND;
        endcase
      end
      OPC_OP_32, OPC_OP_IMM_32: begin
        if (IS64) begin
          case (funct3_i)
            3'b000:  alu_sel_o = (opcode_i == OPC_OP_32 && inst30_i) ? ALU_SUBW : ALU_ADDW;
            3'b001:  alu_sel_o = ALU_SLLW;
            3'b101:  alu_sel_o = inst30_i ? ALU_SRAW : ALU_SRLW;
            default: alu_sel_o = ALU_ADDW;
          endcase
        end
      end
      OPC_LUI: begin
        alu_sel_o = ALU_COPYB;
        imm_sel_o = IMM_U;
      end
      OPC_AUIPC:  imm_sel_o = IMM_U;
      OPC_STORE:  imm_sel_o = IMM_S;
      OPC_BRANCH: imm_sel_o = IMM_B;
      OPC_JAL:    imm_sel_o = IMM_J;
      default:    imm_sel_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// with a TRAP state for illegal instructions. Strobes are Mealy outputs of the
// state so fetch/memory completion and branch outcome act in the same cycle.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TRAP_STICKY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst,
  input  logic               BrEq,
  input  logic               BrLt,
  multicycle_ctrl_if.master  mem,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSel,
  output logic               RegWEn,
  output logic               BrUn,
  output logic               ASel,
  output logic               BSel,
  output logic [1:0]         WBSel,
  output logic [2:0]         ImmSel,
  output logic [3:0]         ALUSel,
  output logic               illegal,
  output logic               halted,
  output state_t             state_o
);

  localparam bit IS64   = (XLEN == 64);
  localparam bit HSHAKE = (MEM_HANDSHAKE != 0);
  localparam bit STICKY = (TRAP_STICKY != 0);

  state_t     state_q;
  logic       illegal_q;
  logic       halted_q;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       ack;
  logic       legal;
  logic       is_load, is_store, is_branch, is_jump;
  logic       br_taken, op_asel, op_bsel;
  logic [3:0] dec_alu;
  logic [2:0] dec_imm;
  logic       mem_req_c, iord_c, memrw_c;
  logic       unused_inst_bits;

  assign opc       = inst[6:2];
  assign f3        = inst[14:12];
  assign ack       = HSHAKE ? mem.mem_ack : 1'b1;
  assign legal     = inst_legal(inst[6:0], f3, IS64);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
  // funct3[2] picks the BrLt compare, funct3[0] inverts the sense (BNE/BGE/BGEU)
  assign br_taken  = f3[2] ? (BrLt ^ f3[0]) : (BrEq ^ f3[0]);
  assign op_asel   = (opc == OPC_AUIPC) || is_branch || (opc == OPC_JAL);
  assign op_bsel   = !((opc == OPC_OP) || (opc == OPC_OP_32));
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  alu_decode #(.XLEN(XLEN)) u_alu_decode (
    .opcode_i  (opc),
    .funct3_i  (f3),
    .inst30_i  (inst[30]),
    .alu_sel_o (dec_alu),
    .imm_sel_o (dec_imm)
  );

  // State sequencing plus the registered illegal pulse and sticky halt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH:  if (ack) state_q <= S_DECODE;
        S_DECODE: begin
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
            if (STICKY) halted_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_load || is_store)      state_q <= S_MEM;
          else if (is_branch || is_jump) state_q <= S_FETCH;
          else                          state_q <= S_WB;
        end
        S_MEM:    if (ack) state_q <= is_store ? S_FETCH : S_WB;
        S_WB:     state_q <= S_FETCH;
        S_TRAP:   if (!STICKY) state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Datapath controls; everything forced to 0 while rst is high
  always_comb begin
    mem_req_c = 1'b0;
    iord_c    = 1'b0;
    memrw_c   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSel     = 1'b0;
    RegWEn    = 1'b0;
    BrUn      = 1'b0;
    ASel      = 1'b0;
    BSel      = 1'b0;
    WBSel     = WB_MEM;
    ImmSel    = IMM_I;
    ALUSel    = ALU_ADD;
    if (!rst) begin
      // Operand selects stay stable for the whole execute/memory/write-back span
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        ALUSel = dec_alu;
        ImmSel = dec_imm;
        ASel   = op_asel;
        BSel   = op_bsel;
      end
      case (state_q)
        S_FETCH: begin
          mem_req_c = 1'b1;
          if (ack) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            BrUn = f3[1];
            if (br_taken) begin
              PCWrite = 1'b1;
              PCSel   = 1'b1;
            end
          end else if (is_jump) begin
            RegWEn  = 1'b1;
            WBSel   = WB_PC4;
            PCWrite = 1'b1;
            PCSel   = 1'b1;
          end
        end
        S_MEM: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
          memrw_c   = is_store;
        end
        S_WB: begin
          RegWEn = 1'b1;
          WBSel  = is_load ? WB_MEM : WB_ALU;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.IorD    = iord_c;
  assign mem.MemRW   = memrw_c;
  assign illegal     = illegal_q;
  assign halted      = halted_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a 32-bit sticky-trap instance is
// scoreboarded cycle by cycle; a 64-bit non-sticky instance on the same
// stimulus covers the W-opcodes and trap recovery.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0000_0013;
  logic        BrEq = 1'b0;
  logic        BrLt = 1'b0;
  logic        mem_ack = 1'b0;

  logic       IRWrite, PCWrite, PCSel, RegWEn, BrUn, ASel, BSel, illegal, halted;
  logic [1:0] WBSel;
  logic [2:0] ImmSel;
  logic [3:0] ALUSel;
  state_t     st;

  logic       IRWrite_64, PCWrite_64, PCSel_64, RegWEn_64, BrUn_64, ASel_64, BSel_64;
  logic       illegal_64, halted_64;
  logic [1:0] WBSel_64;
  logic [2:0] ImmSel_64;
  logic [3:0] ALUSel_64;
  state_t     st_64;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  multicycle_ctrl_if mif();
  multicycle_ctrl_if mif64();
  assign mif.mem_ack   = mem_ack;
  assign mif64.mem_ack = mem_ack;

  multicycle_ctrl #(.XLEN(32), .MEM_HANDSHAKE(1), .TRAP_STICKY(1)) dut (
    .clk(clk), .rst(rst), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem(mif),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel), .RegWEn(RegWEn), .BrUn(BrUn),
    .ASel(ASel), .BSel(BSel), .WBSel(WBSel), .ImmSel(ImmSel), .ALUSel(ALUSel),
    .illegal(illegal), .halted(halted), .state_o(st)
  );

  multicycle_ctrl #(.XLEN(64), .MEM_HANDSHAKE(1), .TRAP_STICKY(0)) dut64 (
    .clk(clk), .rst(rst), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem(mif64),
    .IRWrite(IRWrite_64), .PCWrite(PCWrite_64), .PCSel(PCSel_64), .RegWEn(RegWEn_64),
    .BrUn(BrUn_64), .ASel(ASel_64), .BSel(BSel_64), .WBSel(WBSel_64), .ImmSel(ImmSel_64),
    .ALUSel(ALUSel_64), .illegal(illegal_64), .halted(halted_64), .state_o(st_64)
  );

  // Clock
  always #5 clk = ~clk;

  // Packed observation: {mem_req,IorD,MemRW,IRWrite,PCWrite,PCSel,RegWEn,BrUn,ASel,BSel,WBSel,ImmSel,ALUSel}
  function automatic logic [18:0] v(input logic mreq, iord, mrw, irw, pcw, pcs, rwe, brun,
                                    asel, bsel, input logic [1:0] wbs, input logic [2:0] imm,
                                    input logic [3:0] alu);
    return {mreq, iord, mrw, irw, pcw, pcs, rwe, brun, asel, bsel, wbs, imm, alu};
  endfunction

  function automatic logic [18:0] obs();
    return {mif.mem_req, mif.IorD, mif.MemRW, IRWrite, PCWrite, PCSel, RegWEn, BrUn,
            ASel, BSel, WBSel, ImmSel, ALUSel};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_fetch_ack();
    exp_q.push_back(v(1,0,0,1,1,0,0,0,0,0,WB_MEM,IMM_I,ALU_ADD));
  endtask

  task automatic push_zero();
    exp_q.push_back(19'd0);
  endtask

  // Run n cycles; inst/branch inputs set in the first (FETCH) cycle, acks[c] per cycle
  task automatic run(input string tag, input logic [31:0] i_val, input logic beq, input logic blt,
                     input int n, input logic [15:0] acks);
    logic [18:0] want;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        inst = i_val;
        BrEq = beq;
        BrLt = blt;
      end
      mem_ack = acks[c];
      #1;
      check($sformatf("%s_sb_nonempty", tag), exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check($sformatf("%s_c%0d", tag, c + 1), obs(), want);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b0;
    inst = 32'h0000_0013;
    BrEq = 1'b0;
    BrLt = 1'b0;
    #1;
    check("rst_outputs", obs(), 0);
    check("rst_state", st, S_FETCH);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_halted64", halted_64, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_req", mif.mem_req, 1);
  endtask

  initial begin
    do_reset();

    // add x3,x1,x2: RegWEn only in cycle 4
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,WB_MEM,IMM_I,ALU_ADD));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0,WB_ALU,IMM_I,ALU_ADD));
    run("add", 32'h002081B3, 0, 0, 4, 16'hFFFF);

    // add with one fetch wait cycle: no writes until ack
    exp_q.push_back(v(1,0,0,0,0,0,0,0,0,0,WB_MEM,IMM_I,ALU_ADD));
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,WB_MEM,IMM_I,ALU_ADD));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0,WB_ALU,IMM_I,ALU_ADD));
    run("add_fwait", 32'h002081B3, 0, 0, 5, 16'hFFFE);

    // sub x4,x1,x2 uses inst[30]
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,WB_MEM,IMM_I,ALU_SUB));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0,WB_ALU,IMM_I,ALU_SUB));
    run("sub", 32'h40208233, 0, 0, 4, 16'hFFFF);

    // addi x1,x0,0x400: inst[30] set but ignored
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_I,ALU_ADD));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,1,WB_ALU,IMM_I,ALU_ADD));
    run("addi", 32'h40000093, 0, 0, 4, 16'hFFFF);

    // srai x1,x1,3
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_I,ALU_SRA));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,1,WB_ALU,IMM_I,ALU_SRA));
    run("srai", 32'h4030D093, 0, 0, 4, 16'hFFFF);

    // lui x1,0x12345
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_U,ALU_COPYB));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,1,WB_ALU,IMM_U,ALU_COPYB));
    run("lui", 32'h123450B7, 0, 0, 4, 16'hFFFF);

    // lw x5,0(x1) with two MEM wait cycles: 7 cycles, RegWEn in cycle 7
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_I,ALU_ADD));
    for (int k = 0; k < 3; k++) exp_q.push_back(v(1,1,0,0,0,0,0,0,0,1,WB_MEM,IMM_I,ALU_ADD));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,1,WB_MEM,IMM_I,ALU_ADD));
    run("lw", 32'h0000A283, 0, 0, 7, 16'b0000_0000_0110_0111);

    // sw x2,4(x1): 4 cycles
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_S,ALU_ADD));
    exp_q.push_back(v(1,1,1,0,0,0,0,0,0,1,WB_MEM,IMM_S,ALU_ADD));
    run("sw", 32'h0020A223, 0, 0, 4, 16'hFFFF);

    // Branches: beq taken / not taken, bltu taken, bge not taken
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,1,1,0,0,1,1,WB_MEM,IMM_B,ALU_ADD));
    run("beq_t", 32'h00208463, 1, 0, 3, 16'hFFFF);
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,1,1,WB_MEM,IMM_B,ALU_ADD));
    run("beq_nt", 32'h00208463, 0, 1, 3, 16'hFFFF);
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,1,1,0,1,1,1,WB_MEM,IMM_B,ALU_ADD));
    run("bltu_t", 32'h0020E463, 0, 1, 3, 16'hFFFF);
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,1,1,WB_MEM,IMM_B,ALU_ADD));
    run("bge_nt", 32'h0020D463, 0, 1, 3, 16'hFFFF);

    // jal x1,16 and jalr x1,0(x2)
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,1,1,1,0,1,1,WB_PC4,IMM_J,ALU_ADD));
    run("jal", 32'h010000EF, 0, 0, 3, 16'hFFFF);
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,1,1,1,0,0,1,WB_PC4,IMM_I,ALU_ADD));
    run("jalr", 32'h000100E7, 0, 0, 3, 16'hFFFF);

    // sw with reset asserted mid-MEM: everything drops at once, restart at FETCH
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,1,WB_MEM,IMM_S,ALU_ADD));
    exp_q.push_back(v(1,1,1,0,0,0,0,0,0,1,WB_MEM,IMM_S,ALU_ADD));
    run("sw_rst", 32'h0020A223, 0, 0, 4, 16'h0007);
    @(negedge clk);
    check("sw_rst_pre_state", st, S_MEM);
    rst = 1'b1;
    #1;
    check("sw_rst_outputs", obs(), 0);
    check("sw_rst_state", st, S_FETCH);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("sw_rst_refetch", mif.mem_req, 1);
    push_fetch_ack(); push_zero();
    exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,WB_MEM,IMM_I,ALU_ADD));
    exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0,WB_ALU,IMM_I,ALU_ADD));
    run("add_after_rst", 32'h002081B3, 0, 0, 4, 16'hFFFF);

    // addw: traps on XLEN=32, executes as ADDW on XLEN=64
    push_fetch_ack(); push_zero(); push_zero();
    run("addw32", 32'h003100BB, 0, 0, 3, 16'hFFFF);
    check("addw32_illegal", illegal, 1);
    check("addw32_state", st, S_TRAP);
    check("addw64_exec_state", st_64, S_EXEC);
    check("addw64_exec_alu", ALUSel_64, ALU_ADDW);
    @(negedge clk);
    #1;
    check("addw64_wb_state", st_64, S_WB);
    check("addw64_wb_rwe", RegWEn_64, 1);
    check("addw64_wb_alu", ALUSel_64, ALU_ADDW);
    check("addw64_wb_wbsel", WBSel_64, WB_ALU);
    do_reset();

    // Opcode 7'b1111111: one illegal pulse, sticky halt, no requests for 10 cycles
    push_fetch_ack(); push_zero(); push_zero();
    run("ill", 32'hFFFFFFFF, 0, 0, 3, 16'hFFFF);
    check("ill_pulse", illegal, 1);
    check("ill_halted", halted, 1);
    check("ill64_pulse", illegal_64, 1);
    check("ill64_not_halted", halted_64, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check($sformatf("ill_hold%0d_req", k), mif.mem_req, 0);
      check($sformatf("ill_hold%0d_pulse", k), illegal, 0);
      check($sformatf("ill_hold%0d_halted", k), halted, 1);
      if (k == 0) begin
        check("ill64_resume_state", st_64, S_FETCH);
        check("ill64_resume_req", mif64.mem_req, 1);
        check("ill64_pulse_gone", illegal_64, 0);
      end
    end
    do_reset();

    // inst[1:0] != 2'b11 traps
    push_fetch_ack(); push_zero(); push_zero();
    run("lowbits", 32'h002081B0, 0, 0, 3, 16'hFFFF);
    check("lowbits_illegal", illegal, 1);
    do_reset();

    // Branch funct3 010 is reserved
    push_fetch_ack(); push_zero(); push_zero();
    run("br010", 32'h0020A463, 1, 1, 3, 16'hFFFF);
    check("br010_state", st, S_TRAP);
    do_reset();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
